// File: rtl/sprite_pkg.sv
// Shared types and helpers for the per-scanline sprite mapper.
// Geometry (coordinate width, ID width, sprite edge) is fixed here so the
// table and slot structs have concrete widths. The optional per-sprite
// horizontal flip is enabled by defining SPRITE_MAPPER_FLIP_EN.
package sprite_pkg;

  localparam int COORD_W     = 10;
  localparam int ID_W        = 4;
  localparam int SPRITE_SIZE = 32;                 // power of two
  localparam int LOG2        = $clog2(SPRITE_SIZE);

  localparam logic [ID_W-1:0] TRANSPARENT_ID = '1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SCAN,
    COMMIT
  } scan_state_t;

  // One sprite table entry (top-left corner plus ID)
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [ID_W-1:0]    id;
`ifdef SPRITE_MAPPER_FLIP_EN
    logic               flip;
`endif
  } sprite_entry_t;

  // One per-line slot: horizontal position plus the row already resolved
  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [LOG2-1:0]    row;
    logic [ID_W-1:0]    id;
`ifdef SPRITE_MAPPER_FLIP_EN
    logic               flip;
`endif
  } slot_t;

  // Unsigned coordinates subtracted as COORD_W+1-bit signed, so an object
  // above/left of the probe point yields a negative result instead of wrapping.
  function automatic logic [COORD_W:0] coord_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  // True when 0 <= d < SPRITE_SIZE
  function automatic logic in_span(input logic [COORD_W:0] d);
    return !d[COORD_W] && (d[COORD_W-1:0] < COORD_W'(SPRITE_SIZE));
  endfunction

endpackage

// File: rtl/sprite_slot_match.sv
// Horizontal hit test for one active slot: reports whether DrawX falls inside
// the sprite and the column offset within it.
module sprite_slot_match
  import sprite_pkg::*;
(
  input  logic               valid,
  input  logic [COORD_W-1:0] slot_x,
  input  logic [COORD_W-1:0] draw_x,
  output logic               hit,
  output logic [LOG2-1:0]    dx_lo
);

  logic [COORD_W:0] dx;

  // Signed column offset and range check
  always_comb begin
    dx    = coord_diff(draw_x, slot_x);
    hit   = valid && in_span(dx);
    dx_lo = dx[LOG2-1:0];
  end

endmodule

// File: rtl/sprite_line_mapper.sv
// Per-scanline sprite mapper.
// During hblank a scan walks the sprite table one entry per cycle and stages
// up to SLOTS sprites that cover the next line; COMMIT publishes them to the
// active slots in one cycle so the visible line never tears. During active
// video each DrawX is resolved against the active slots with fixed priority
// (lowest slot = lowest table index) and registered to the outputs.
// Optional feature macro: SPRITE_MAPPER_FLIP_EN adds wr_flip and mirrors
// the column offset of flipped sprites.
module sprite_line_mapper
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 16,
  parameter int SLOTS       = 8
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_SPRITES)-1:0] wr_idx,
  input  logic [COORD_W-1:0]             wr_x,
  input  logic [COORD_W-1:0]             wr_y,
  input  logic [ID_W-1:0]                wr_id,
`ifdef SPRITE_MAPPER_FLIP_EN
  input  logic                           wr_flip,
`endif
  input  logic                           line_start,
  input  logic [COORD_W-1:0]             next_y,
  input  logic [COORD_W-1:0]             DrawX,
  output logic                           scan_busy,
  output logic                           overflow,
  output logic [ID_W-1:0]                spriteIDOut,
  output logic [LOG2-1:0]                sPosXOut,
  output logic [LOG2-1:0]                sPosYOut
);

  localparam int IDX_W  = $clog2(NUM_SPRITES);
  localparam int CNT_W  = $clog2(SLOTS + 1);
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  sprite_entry_t table_q [NUM_SPRITES];
  sprite_entry_t table_d [NUM_SPRITES];

  scan_state_t        state_q, state_d;
  logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
  logic [COORD_W-1:0] line_y_q, line_y_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic               staging_ovf_q, staging_ovf_d;
  logic               overflow_q, overflow_d;
  slot_t              staging_q [SLOTS];
  slot_t              staging_d [SLOTS];
  slot_t              active_q  [SLOTS];
  slot_t              active_d  [SLOTS];

  logic [ID_W-1:0]    pix_id_q, pix_id_d;
  logic [LOG2-1:0]    pix_x_q, pix_x_d;
  logic [LOG2-1:0]    pix_y_q, pix_y_d;

  sprite_entry_t      cur_entry;
  logic [COORD_W:0]   dy;
  logic               scan_hit;
  slot_t              new_slot;

  logic [SLOTS-1:0]   slot_hit;
  logic [LOG2-1:0]    slot_dx [SLOTS];

  // Table write port: an entry is visible to the scanner the cycle after wr_en
  always_comb begin
    table_d = table_q;
    if (wr_en) begin
      table_d[wr_idx].x  = wr_x;
      table_d[wr_idx].y  = wr_y;
      table_d[wr_idx].id = wr_id;
`ifdef SPRITE_MAPPER_FLIP_EN
      table_d[wr_idx].flip = wr_flip;
`endif
    end
  end

  // Scan FSM: next state, staging fill and commit to the active slots
  always_comb begin
    state_d       = state_q;
    scan_idx_d    = scan_idx_q;
    line_y_d      = line_y_q;
    hit_cnt_d     = hit_cnt_q;
    staging_d     = staging_q;
    staging_ovf_d = staging_ovf_q;
    active_d      = active_q;
    overflow_d    = overflow_q;

    cur_entry = table_q[scan_idx_q];
    dy        = coord_diff(line_y_q, cur_entry.y);
    scan_hit  = (cur_entry.id != TRANSPARENT_ID) && in_span(dy);

    new_slot       = '0;
    new_slot.valid = 1'b1;
    new_slot.x     = cur_entry.x;
    new_slot.row   = dy[LOG2-1:0];
    new_slot.id    = cur_entry.id;
`ifdef SPRITE_MAPPER_FLIP_EN
    new_slot.flip  = cur_entry.flip;
`endif

    if (line_start) begin
      // A new pulse always restarts; active slots are left untouched
      state_d  = CLEAR;
      line_y_d = next_y;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        CLEAR: begin
          for (int k = 0; k < SLOTS; k++) begin
            staging_d[k] = '0;
          end
          hit_cnt_d     = '0;
          staging_ovf_d = 1'b0;
          scan_idx_d    = '0;
          state_d       = SCAN;
        end
        SCAN: begin
          if (scan_hit) begin
            if (hit_cnt_q < CNT_W'(SLOTS)) begin
              staging_d[hit_cnt_q[SLOT_W-1:0]] = new_slot;
              hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end else begin
              staging_ovf_d = 1'b1;
            end
          end
          if (scan_idx_q == IDX_W'(NUM_SPRITES - 1)) begin
            state_d = COMMIT;
          end else begin
            scan_idx_d = scan_idx_q + IDX_W'(1);
          end
        end
        COMMIT: begin
          active_d   = staging_q;
          overflow_d = staging_ovf_q;
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Horizontal hit test, one matcher per active slot
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_match
      sprite_slot_match u_match (
        .valid  (active_q[gi].valid),
        .slot_x (active_q[gi].x),
        .draw_x (DrawX),
        .hit    (slot_hit[gi]),
        .dx_lo  (slot_dx[gi])
      );
    end
  endgenerate

  // Priority pick: walk from the highest slot down so the lowest hit wins
  always_comb begin
    pix_id_d = TRANSPARENT_ID;
    pix_x_d  = '0;
    pix_y_d  = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (slot_hit[k]) begin
        pix_id_d = active_q[k].id;
        pix_y_d  = active_q[k].row;
`ifdef SPRITE_MAPPER_FLIP_EN
        pix_x_d  = active_q[k].flip ? (LOG2'(SPRITE_SIZE - 1) - slot_dx[k]) : slot_dx[k];
`else
        pix_x_d  = slot_dx[k];
`endif
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        table_q[k]    <= '0;
        table_q[k].id <= TRANSPARENT_ID;
      end
      for (int k = 0; k < SLOTS; k++) begin
        staging_q[k] <= '0;
        active_q[k]  <= '0;
      end
      state_q       <= IDLE;
      scan_idx_q    <= '0;
      line_y_q      <= '0;
      hit_cnt_q     <= '0;
      staging_ovf_q <= 1'b0;
      overflow_q    <= 1'b0;
      pix_id_q      <= TRANSPARENT_ID;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
    end else begin
      table_q       <= table_d;
      staging_q     <= staging_d;
      active_q      <= active_d;
      state_q       <= state_d;
      scan_idx_q    <= scan_idx_d;
      line_y_q      <= line_y_d;
      hit_cnt_q     <= hit_cnt_d;
      staging_ovf_q <= staging_ovf_d;
      overflow_q    <= overflow_d;
      pix_id_q      <= pix_id_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
    end
  end

  assign scan_busy   = (state_q != IDLE);
  assign overflow    = overflow_q;
  assign spriteIDOut = pix_id_q;
  assign sPosXOut    = pix_x_q;
  assign sPosYOut    = pix_y_q;

endmodule
